// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared elevator types, sizing constants and floor-match helper
package elevator_pkg;
   localparam int NUM_FLOORS = 6;
   localparam int HALF_POS_W = 4;

   typedef enum logic [1:0] {
      START  = 2'd0,
      SIM    = 2'd1,
      PAUSE  = 2'd2,
      ENDING = 2'd3
   } sim_state_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      ASG_L   = 2'd2,
      ASG_R   = 2'd3
   } call_state_t;

   // Out-of-range positions (> 2*(NUM_FLOORS-1)) can never equal 2*f, so they match nothing.
   function automatic logic at_floor(input logic [HALF_POS_W-1:0] pos, input int f);
      return {1'b0, pos} == 5'(2 * f);
   endfunction
endpackage

// File: rtl/call_cost.sv
// rtl/call_cost.sv - cost of sending one car to one floor; DISPATCH_DIRECTION_PENALTY_EN adds the away-from-call penalty
module call_cost
   import elevator_pkg::*;
#(
   parameter int FLOORS       = elevator_pkg::NUM_FLOORS,
   parameter int AWAY_PENALTY = 4,
   parameter int FLOOR_W      = $clog2(FLOORS)
) (
   input  logic [HALF_POS_W-1:0] i_pos,
   input  logic                  i_dir,
   input  logic [FLOOR_W-1:0]    i_floor,
   output logic [4:0]            o_cost
);
`ifdef DISPATCH_DIRECTION_PENALTY_EN
   localparam bit PENALTY_EN = 1'b1;
`else
   localparam bit PENALTY_EN = 1'b0;
`endif
   localparam logic [4:0] MAX_POS = 5'(2 * (FLOORS - 1));

   logic [4:0] w_pos;
   logic [4:0] w_target;
   logic [4:0] w_dist;
   logic       w_away;

   always_comb begin
      w_pos    = 5'(i_pos);
      w_target = 5'({i_floor, 1'b0});
      w_dist   = (w_pos >= w_target) ? (w_pos - w_target) : (w_target - w_pos);
      w_away   = PENALTY_EN && ((i_dir && (w_pos > w_target)) || (!i_dir && (w_pos < w_target)));
      if (w_pos > MAX_POS)
         o_cost = 5'd31;
      else if (w_away)
         o_cost = w_dist + 5'(AWAY_PENALTY);
      else
         o_cost = w_dist;
   end
endmodule

// File: rtl/hall_call_dispatcher.sv
// rtl/hall_call_dispatcher.sv - hall-call latch, left/right car arbiter and per-car door dwell
// Optional direction penalty in call_cost is enabled by DISPATCH_DIRECTION_PENALTY_EN.
module hall_call_dispatcher
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS   = elevator_pkg::NUM_FLOORS,
   parameter int DWELL_CYCLES = 8,
   parameter int AWAY_PENALTY = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              simState,
   input  logic [NUM_FLOORS-1:0]   hall_buttons,
   input  logic [2*HALF_POS_W-1:0] half_elevatorPositions,
   input  logic [1:0]              directions,
   output logic [2*NUM_FLOORS-1:0] FloorsRequested,
   output logic [NUM_FLOORS-1:0]   pending_calls,
   output logic [1:0]              door_open
);
   localparam int FLOOR_W = $clog2(NUM_FLOORS);
   localparam int DW_W    = $clog2(DWELL_CYCLES + 1);

   call_state_t             r_state     [NUM_FLOORS];
   call_state_t             w_state_nxt [NUM_FLOORS];
   logic [DW_W-1:0]         r_dwell     [2];
   logic [DW_W-1:0]         w_dwell_nxt [2];
   logic [2*NUM_FLOORS-1:0] r_floors_req, w_req_nxt;
   logic [NUM_FLOORS-1:0]   r_pending, w_pend_nxt;
   logic [1:0]              r_door, w_load, w_imm;
   logic [HALF_POS_W-1:0]   w_pos [2];
   sim_state_t              w_mode;
   logic                    w_sim, w_live, w_clear;
   logic [FLOOR_W-1:0]      w_sel;
   logic [4:0]              w_cost_l, w_cost_r;

   // Arbiter pick: lowest-index PENDING floor feeds both cost units.
   always_comb begin
      w_mode   = sim_state_t'(simState);
      w_sim    = (w_mode == SIM);
      w_live   = w_sim || (w_mode == PAUSE);
      w_clear  = rst || (w_mode == START) || (w_mode == ENDING);
      w_pos[0] = half_elevatorPositions[HALF_POS_W-1:0];
      w_pos[1] = half_elevatorPositions[2*HALF_POS_W-1:HALF_POS_W];
      w_sel    = '0;
      for (int i = NUM_FLOORS - 1; i >= 0; i--)
         if (r_state[i] == PENDING) w_sel = FLOOR_W'(i);
   end

   call_cost #(.FLOORS(NUM_FLOORS), .AWAY_PENALTY(AWAY_PENALTY)) u_cost_l (
      .i_pos(w_pos[0]), .i_dir(directions[0]), .i_floor(w_sel), .o_cost(w_cost_l)
   );
   call_cost #(.FLOORS(NUM_FLOORS), .AWAY_PENALTY(AWAY_PENALTY)) u_cost_r (
      .i_pos(w_pos[1]), .i_dir(directions[1]), .i_floor(w_sel), .o_cost(w_cost_r)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 2'b00;
      w_imm       = 2'b00;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         unique case (r_state[i])
            IDLE: begin
               // A press at a floor where a car already stands with its door open is absorbed.
               w_imm[0] = w_sim && r_door[0] && at_floor(w_pos[0], i);
               w_imm[1] = w_sim && r_door[1] && at_floor(w_pos[1], i);
               if (w_live && hall_buttons[i]) begin
                  w_load = w_load | w_imm;
                  if (w_imm == 2'b00) w_state_nxt[i] = PENDING;
               end
            end
            PENDING:
               if (w_sim && (w_sel == FLOOR_W'(i)))
                  w_state_nxt[i] = (w_cost_r < w_cost_l) ? ASG_R : ASG_L;
            ASG_L:
               if (w_sim && at_floor(w_pos[0], i)) begin
                  w_state_nxt[i] = IDLE;
                  w_load[0]      = 1'b1;
               end
            ASG_R:
               if (w_sim && at_floor(w_pos[1], i)) begin
                  w_state_nxt[i] = IDLE;
                  w_load[1]      = 1'b1;
               end
            default: ;
         endcase
      end

      w_req_nxt  = '0;
      w_pend_nxt = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         w_pend_nxt[i]             = (w_state_nxt[i] == PENDING);
         w_req_nxt[i]              = (w_state_nxt[i] == ASG_L);
         w_req_nxt[NUM_FLOORS + i] = (w_state_nxt[i] == ASG_R);
      end

      for (int c = 0; c < 2; c++) begin
         if (w_load[c])
            w_dwell_nxt[c] = DW_W'(DWELL_CYCLES);
         else if (w_sim && (r_dwell[c] != '0))
            w_dwell_nxt[c] = r_dwell[c] - 1'b1;
         else
            w_dwell_nxt[c] = r_dwell[c];
      end
   end

   always_ff @(posedge clk) begin
      if (w_clear) begin
         for (int i = 0; i < NUM_FLOORS; i++) r_state[i] <= IDLE;
         r_dwell[0]   <= '0;
         r_dwell[1]   <= '0;
         r_floors_req <= '0;
         r_pending    <= '0;
         r_door       <= 2'b00;
      end else begin
         r_state      <= w_state_nxt;
         r_dwell      <= w_dwell_nxt;
         r_floors_req <= w_req_nxt;
         r_pending    <= w_pend_nxt;
         r_door       <= {w_dwell_nxt[1] != '0, w_dwell_nxt[0] != '0};
      end
   end

   assign FloorsRequested = r_floors_req;
   assign pending_calls   = r_pending;
   assign door_open       = r_door;
endmodule
